// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bus: stall/branch feedback from the pipeline in,
// PC, flush and validity information back out.
interface pc_fetch_ctrl_if #(
    parameter int PC_WIDE = 7
);
    logic               stall;
    logic               branch_taken;
    logic [PC_WIDE-1:0] branch_pc;
    logic [PC_WIDE-1:0] pc;
    logic [PC_WIDE-1:0] pc_next;
    logic               if_valid;
    logic               flush;
    logic               redirect_pending;

    // Pipeline / execute side
    modport master (
        output stall, branch_taken, branch_pc,
        input  pc, pc_next, if_valid, flush, redirect_pending
    );

    // Fetch controller side
    modport slave (
        input  stall, branch_taken, branch_pc,
        output pc, pc_next, if_valid, flush, redirect_pending
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC controller: owns the PC, applies branch redirects (holding
// them across stalls) and raises a fixed-length flush window afterwards.
module pc_fetch_ctrl #(
    parameter int PC_WIDE     = 7,
    parameter int RESET_PC    = 0,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

    state_t             state;
    logic [PC_WIDE-1:0] pc_q;
    logic [PC_WIDE-1:0] pend_pc;
    logic [2:0]         flush_cnt;
    logic               flush_q;
    logic               valid_q;
    logic               pending_q;
    logic [PC_WIDE-1:0] seq_pc;

    // Sequential PC, wraps naturally at 2^PC_WIDE
    always_comb begin
        seq_pc = pc_q + PC_WIDE'(1);
    end

    assign bus.pc               = pc_q;
    assign bus.pc_next          = seq_pc;
    assign bus.flush            = flush_q;
    assign bus.if_valid         = valid_q;
    assign bus.redirect_pending = pending_q;

    // Fetch FSM: PC update, redirect capture and flush window timing
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pc_q      <= PC_WIDE'(RESET_PC);
            pend_pc   <= '0;
            flush_cnt <= '0;
            flush_q   <= 1'b0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!bus.stall) begin
                        if (bus.branch_taken) begin
                            pc_q      <= bus.branch_pc;
                            state     <= FLUSH;
                            flush_cnt <= 3'(FLUSH_DEPTH);
                            flush_q   <= 1'b1;
                            valid_q   <= 1'b0;
                        end else begin
                            pc_q    <= seq_pc;
                            valid_q <= 1'b1;
                        end
                    end else if (bus.branch_taken) begin
                        pend_pc   <= bus.branch_pc;
                        pending_q <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    // later branch_taken pulses are the same frozen branch; first target wins
                    if (!bus.stall) begin
                        pc_q      <= pend_pc;
                        pending_q <= 1'b0;
                        state     <= FLUSH;
                        flush_cnt <= 3'(FLUSH_DEPTH);
                        flush_q   <= 1'b1;
                        valid_q   <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (!bus.stall) begin
                        pc_q      <= seq_pc;
                        flush_cnt <= flush_cnt - 3'd1;
                        if (flush_cnt == 3'd1) begin
                            state   <= RUN;
                            flush_q <= 1'b0;
                            valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end
endmodule
